// File: rtl/regfile_wb_arbiter_if.sv
// Writeback arbiter bus: ALU queue handshake, load return,
// hazard lookup and register file write port.
interface regfile_wb_arbiter_if;
  logic        alu_valid;
  logic [4:0]  alu_dest;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        load_issue;
  logic [4:0]  load_dest;
  logic        load_valid;
  logic [4:0]  load_rdest;
  logic [31:0] load_data;
  logic [4:0]  readR1;
  logic [4:0]  readR2;
  logic        busy1;
  logic        busy2;
  logic        RegWrite;
  logic [4:0]  writeR;
  logic [31:0] writedata;

  modport master (
    output alu_valid, alu_dest, alu_data,
    output load_issue, load_dest,
    output load_valid, load_rdest, load_data,
    output readR1, readR2,
    input  alu_ready, busy1, busy2,
    input  RegWrite, writeR, writedata
  );

  modport slave (
    input  alu_valid, alu_dest, alu_data,
    input  load_issue, load_dest,
    input  load_valid, load_rdest, load_data,
    input  readR1, readR2,
    output alu_ready, busy1, busy2,
    output RegWrite, writeR, writedata
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: loads > queued ALU > ALU bypass, plus load
// scoreboard enabled by WB_SCOREBOARD_EN.
module regfile_wb_arbiter #(
  parameter int QDEPTH = 2
) (
  input logic clk,
  input logic reset,
  regfile_wb_arbiter_if.slave wb
);
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);
  localparam logic [CW-1:0] QMAX = CW'(QDEPTH);
  localparam logic [PW-1:0] PLAST = PW'(QDEPTH - 1);

  logic [4:0]    dest_q [QDEPTH];
  logic [4:0]    dest_d [QDEPTH];
  logic [31:0]   data_q [QDEPTH];
  logic [31:0]   data_d [QDEPTH];
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          regwrite_q, regwrite_d;
  logic [4:0]    writer_q, writer_d;
  logic [31:0]   writedata_q, writedata_d;

  logic        alu_rdy, xfer, empty;
  logic        push, pop, sel, bypass;
  logic [4:0]  sel_dest;
  logic [31:0] sel_data;

  always_comb begin
    alu_rdy  = count_q < QMAX;
    xfer     = wb.alu_valid && alu_rdy;
    empty    = count_q == '0;
    pop      = 1'b0;
    sel      = 1'b0;
    bypass   = 1'b0;
    sel_dest = '0;
    sel_data = '0;
    priority case (1'b1)
      wb.load_valid: begin
        sel      = 1'b1;
        sel_dest = wb.load_rdest;
        sel_data = wb.load_data;
      end
      !empty: begin
        sel      = 1'b1;
        pop      = 1'b1;
        sel_dest = dest_q[rptr_q];
        sel_data = data_q[rptr_q];
      end
      xfer: begin
        sel      = 1'b1;
        bypass   = 1'b1;
        sel_dest = wb.alu_dest;
        sel_data = wb.alu_data;
      end
      default: ;
    endcase
    push = xfer && !bypass;

    dest_d = dest_q;
    data_d = data_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push) begin
      dest_d[wptr_q] = wb.alu_dest;
      data_d[wptr_q] = wb.alu_data;
      wptr_d = (wptr_q == PLAST) ? '0 : wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = (rptr_q == PLAST) ? '0 : rptr_q + 1'b1;
    end
    count_d = count_q;
    if (push && !pop) count_d = count_q + 1'b1;
    if (pop && !push) count_d = count_q - 1'b1;

    // $zero is never written, but the slot is still consumed
    regwrite_d  = sel && (sel_dest != 5'd0);
    writer_d    = regwrite_d ? sel_dest : writer_q;
    writedata_d = regwrite_d ? sel_data : writedata_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < QDEPTH; i++) begin
        dest_q[i] <= '0;
        data_q[i] <= '0;
      end
      rptr_q      <= '0;
      wptr_q      <= '0;
      count_q     <= '0;
      regwrite_q  <= 1'b0;
      writer_q    <= '0;
      writedata_q <= '0;
    end else begin
      dest_q      <= dest_d;
      data_q      <= data_d;
      rptr_q      <= rptr_d;
      wptr_q      <= wptr_d;
      count_q     <= count_d;
      regwrite_q  <= regwrite_d;
      writer_q    <= writer_d;
      writedata_q <= writedata_d;
    end
  end

  logic sb1, sb2;

`ifdef WB_SCOREBOARD_EN
  logic [31:0] sb_q, sb_d;

  // set after clear: a reissue wins over the old return
  always_comb begin
    sb_d = sb_q;
    if (wb.load_valid) sb_d[wb.load_rdest] = 1'b0;
    if (wb.load_issue) sb_d[wb.load_dest] = 1'b1;
    sb_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sb_q <= '0;
    else        sb_q <= sb_d;
  end

  assign sb1 = sb_q[wb.readR1];
  assign sb2 = sb_q[wb.readR2];
`else
  logic unused_sb;
  assign unused_sb = ^{wb.load_issue, wb.load_dest};
  assign sb1 = 1'b0;
  assign sb2 = 1'b0;
`endif

  assign wb.busy1 = (wb.readR1 != 5'd0) &&
    (sb1 | (regwrite_q && writer_q == wb.readR1));
  assign wb.busy2 = (wb.readR2 != 5'd0) &&
    (sb2 | (regwrite_q && writer_q == wb.readR2));

  assign wb.alu_ready = alu_rdy;
  assign wb.RegWrite  = regwrite_q;
  assign wb.writeR    = writer_q;
  assign wb.writedata = writedata_q;
endmodule
